control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter PC_RESET, default 8'h00, the program counter value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port instr_in, input, 16, the instruction at address pc, valid combinationally.
REQ-005 SHALL have port a_bus_in, input, 8, the datapath A-bus value for the current control word.
REQ-006 SHALL have ports V, C, N, Z, input, 1 each, the datapath flags for the current control word.
REQ-007 SHALL have port mem_ready, input, 1, data-memory completion strobe.
REQ-008 SHALL have port pc, output, 8, the instruction address.
REQ-009 SHALL have port control_word, output, 16, packed {DA[15:13], AA[12:10], BA[9:7], MB[6], FS[5:2], MD[1], RW[0]}.
REQ-010 SHALL have port constant_out, output, 8, the immediate {2'b00, IR[5:0]}.
REQ-011 SHALL have ports mem_read and mem_write, output, 1 each, data-memory request strobes.
REQ-012 SHALL have port halted, output, 1, high while in HALT.

Function
REQ-013 SHALL latch instr_in into the 16-bit IR at the end of every FETCH cycle; fields op=IR[15:12], DR=IR[11:9], SA=IR[8:6], SB=IR[5:3], ext=IR[2:0].
REQ-014 SHALL implement states FETCH, EXEC, MEM, HALT; FETCH always -> EXEC, except op 6/7 -> MEM and op F -> HALT.
REQ-015 SHALL drive control_word = 16'h0000 and both memory strobes low in FETCH and HALT.
REQ-016 op 0 and undefined ops 5, B-E: EXEC with control_word 0, then pc+1.
REQ-017 op 2/3 (ALU register): DA=DR, AA=SA, BA=SB, MB=0, FS={op[0],ext}, MD=0, RW=1, for exactly one EXEC cycle.
REQ-018 op 4 (add immediate): DA=DR, AA=SA, MB=1, FS=4'b0010, MD=0, RW=1, one EXEC cycle.
REQ-019 op 1 (move): DA=DR, AA=SA, MB=0, FS=4'b0000, RW=1, one EXEC cycle.
REQ-020 op 6 (load): in MEM drive AA=SA, DA=DR, MD=1, mem_read=1, RW=mem_ready; stay in MEM until mem_ready=1, then -> FETCH with pc+1.
REQ-021 op 7 (store): in MEM drive AA=SA, BA=SB, MB=0, RW=0, mem_write=1; stay until mem_ready=1, then -> FETCH with pc+1.
REQ-022 op 8/9 (branch on Z / N): EXEC drives AA=SA, FS=4'b0000, RW=0; if sampled flag =1, pc <= pc + sign-extended IR[5:0], else pc+1.
REQ-023 op A (jump register): EXEC drives AA=SA, RW=0; pc <= a_bus_in.
REQ-024 op F (halt): HALT is absorbing; pc frozen; exit only via reset.
REQ-025 All pc arithmetic SHALL be modulo 256 (8'hFF + 1 = 8'h00; branch offset -1 from 8'h00 = 8'hFF).
REQ-026 pc SHALL update only on the EXEC->FETCH or MEM->FETCH transition; it is stable during FETCH, EXEC, MEM.
REQ-027 mem_ready SHALL be ignored outside MEM; mem_ready high on MEM entry completes in one MEM cycle.
REQ-028 V and C SHALL be accepted but have no effect on sequencing.
REQ-029 Instruction latency: non-memory ops 2 cycles; memory ops 1 + number of MEM cycles.

Reset
REQ-030 On reset low, asynchronously: state=FETCH, pc=PC_RESET, IR=16'h0000, control_word=0, mem_read=0, mem_write=0, halted=0.
REQ-031 Reset asserted mid-MEM SHALL drop strobes immediately and abandon the access with no register write.
REQ-032 After reset release, the first rising edge SHALL perform a FETCH at PC_RESET.

Verification
REQ-033 Reset, instr 16'h2A50 (op2, DR5, SA1, SB2, ext0) at pc 0 -> EXEC control_word 16'hA500|RW=1 i.e. DA=5, AA=1, BA=2, FS=0000, RW=1; pc=1 after 2 cycles.
REQ-034 Load op 6 with mem_ready low for 3 cycles then high -> mem_read high 4 cycles, RW=1 and MD=1 only in final cycle, pc+1 after.
REQ-035 Branch op 8 with IR[5:0]=6'h3E at pc 8'h10, Z=1 -> pc 8'h0E; same with Z=0 -> pc 8'h11.
REQ-036 NOP at pc 8'hFF -> pc wraps to 8'h00.
REQ-037 op F -> halted=1, control_word 0 indefinitely; reset pulse -> pc=PC_RESET, halted=0.
REQ-038 Reset asserted during store MEM wait -> mem_write falls same cycle, state FETCH, pc=PC_RESET.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches 16-bit instructions, decodes them into datapath
// control words, sequences loads/stores against a ready-strobed data memory and handles branches.
module control_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic [7:0]  a_bus_in,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  input  logic        mem_ready,
  output logic [7:0]  pc,
  output logic [15:0] control_word,
  output logic [7:0]  constant_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] MEM   = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

  logic [3:0] op;
  logic [2:0] dr, sa, sb, ext;
  logic [7:0] branchOffset;
  logic       unused_flags;

  assign op           = ir_q[15:12];
  assign dr           = ir_q[11:9];
  assign sa           = ir_q[8:6];
  assign sb           = ir_q[5:3];
  assign ext          = ir_q[2:0];
  assign branchOffset = {{2{ir_q[5]}}, ir_q[5:0]};
  // Overflow and carry travel with the flag bundle but never steer sequencing.
  assign unused_flags = V & C;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // pc only moves when an instruction retires, i.e. on the way back to FETCH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        ir_d = instr_in;
        case (instr_in[15:12])
          4'h6, 4'h7: state_d = MEM;
          4'hF:       state_d = HALT;
          default:    state_d = EXEC;
        endcase
      end
      EXEC: begin
        state_d = FETCH;
        case (op)
          4'h8:    pc_d = Z ? pc_q + branchOffset : pc_q + 8'd1;
          4'h9:    pc_d = N ? pc_q + branchOffset : pc_q + 8'd1;
          4'hA:    pc_d = a_bus_in;
          default: pc_d = pc_q + 8'd1;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          state_d = FETCH;
          pc_d    = pc_q + 8'd1;
        end
      end
      default: state_d = HALT;
    endcase
  end

  logic [2:0] da, aa, ba;
  logic [3:0] fs;
  logic       mb, md, rw;

  always_comb begin
    da = 3'd0;
    aa = 3'd0;
    ba = 3'd0;
    mb = 1'b0;
    fs = 4'd0;
    md = 1'b0;
    rw = 1'b0;
    if (state_q == EXEC) begin
      case (op)
        4'h1: begin
          da = dr;
          aa = sa;
          rw = 1'b1;
        end
        4'h2, 4'h3: begin
          da = dr;
          aa = sa;
          ba = sb;
          fs = {op[0], ext};
          rw = 1'b1;
        end
        4'h4: begin
          da = dr;
          aa = sa;
          mb = 1'b1;
          fs = 4'b0010;
          rw = 1'b1;
        end
        4'h8, 4'h9, 4'hA: aa = sa;
        default: ;
      endcase
    end else if (state_q == MEM) begin
      aa = sa;
      if (op == 4'h6) begin
        da = dr;
        md = 1'b1;
        rw = mem_ready;
      end else begin
        ba = sb;
      end
    end
  end

  assign control_word = {da, aa, ba, mb, fs, md, rw};
  assign mem_read     = (state_q == MEM) && (op == 4'h6);
  assign mem_write    = (state_q == MEM) && (op == 4'h7);
  assign halted       = (state_q == HALT);
  assign pc           = pc_q;
  assign constant_out = {2'b00, ir_q[5:0]};

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: an instruction-level interpreter predicts every cycle's
// outputs, driven by directed programs and then random programs with random flags/ready.
module tb_control_sequencer;

  localparam logic [7:0] PCR = 8'h00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr_in;
  logic [7:0]  a_bus_in = 8'h00;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
  logic        mem_ready = 1'b0;
  logic [7:0]  pc;
  logic [15:0] control_word;
  logic [7:0]  constant_out;
  logic        mem_read, mem_write, halted;

  logic [15:0] imem [256];
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  mpc;
  bit          dirMode;
  logic        dirZ, dirN;
  logic [7:0]  dirABus;
  int          dirWait;
  logic [15:0] lastCw;
  int          lastMemCycles;

  assign instr_in = imem[pc];

  always #5 clk = ~clk;

  control_sequencer #(.PC_RESET(PCR)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .a_bus_in(a_bus_in),
    .V(V), .C(C), .N(N), .Z(Z), .mem_ready(mem_ready),
    .pc(pc), .control_word(control_word), .constant_out(constant_out),
    .mem_read(mem_read), .mem_write(mem_write), .halted(halted)
  );

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] wrapAdd(input logic [7:0] base, input int delta);
    return 8'((int'(base) + delta + 512) % 256);
  endfunction

  // Expected control word assembled field-by-field from the instruction's meaning.
  function automatic logic [15:0] expCw(input logic [15:0] ir, input logic mr);
    int op, dr, sa, sb, ext;
    int da = 0, aa = 0, ba = 0, mb = 0, fs = 0, md = 0, rw = 0;
    op = int'(ir[15:12]); dr = int'(ir[11:9]); sa = int'(ir[8:6]);
    sb = int'(ir[5:3]);   ext = int'(ir[2:0]);
    case (op)
      1:       begin da = dr; aa = sa; rw = 1; end
      2, 3:    begin da = dr; aa = sa; ba = sb; fs = (op - 2) * 8 + ext; rw = 1; end
      4:       begin da = dr; aa = sa; mb = 1; fs = 2; rw = 1; end
      6:       begin da = dr; aa = sa; md = 1; rw = int'(mr); end
      7:       begin aa = sa; ba = sb; end
      8, 9, 10: aa = sa;
      default: ;
    endcase
    return 16'(da * 8192 + aa * 1024 + ba * 128 + mb * 64 + fs * 4 + md * 2 + rw);
  endfunction

  task automatic driveInputs(input int memIdx, output logic mr);
    V = 1'($urandom);
    C = 1'($urandom);
    if (dirMode) begin
      Z = dirZ;
      N = dirN;
      a_bus_in = dirABus;
    end else begin
      Z = 1'($urandom);
      N = 1'($urandom);
      a_bus_in = 8'($urandom);
    end
    if (memIdx < 0)        mr = 1'($urandom);
    else if (dirMode)      mr = (memIdx >= dirWait);
    else if (memIdx >= 4)  mr = 1'b1;
    else                   mr = 1'($urandom);
    mem_ready = mr;
  endtask

  task automatic fetchCycle(output logic [15:0] ir);
    logic mr;
    driveInputs(-1, mr);
    @(negedge clk);
    checkVal("fetch_pc", 16'(pc), 16'(mpc));
    checkVal("fetch_cw", control_word, 16'h0000);
    checkVal("fetch_strobes", 16'({mem_read, mem_write, halted}), 16'h0000);
    ir = imem[mpc];
    @(posedge clk); #1;
  endtask

  task automatic executeInstr(input logic [15:0] ir);
    logic mr;
    int   op, idx, off;
    op  = int'(ir[15:12]);
    off = ir[5] ? int'(ir[5:0]) - 64 : int'(ir[5:0]);
    if (op == 15) begin
      for (int k = 0; k < 4; k++) begin
        driveInputs(-1, mr);
        @(negedge clk);
        checkVal("halt_flag", 16'(halted), 16'h0001);
        checkVal("halt_cw", control_word, 16'h0000);
        checkVal("halt_pc", 16'(pc), 16'(mpc));
        checkVal("halt_strobes", 16'({mem_read, mem_write}), 16'h0000);
        @(posedge clk); #1;
      end
    end else if (op == 6 || op == 7) begin
      idx = 0;
      do begin
        driveInputs(idx, mr);
        @(negedge clk);
        checkVal("mem_cw", control_word, expCw(ir, mr));
        checkVal("mem_strobes", 16'({mem_read, mem_write}), 16'({op == 6, op == 7}));
        checkVal("mem_pc", 16'(pc), 16'(mpc));
        checkVal("mem_halted", 16'(halted), 16'h0000);
        checkVal("mem_const", 16'(constant_out), ir & 16'h003F);
        lastCw = control_word;
        idx++;
        @(posedge clk); #1;
      end while (!mr && idx < 20);
      lastMemCycles = idx;
      mpc = wrapAdd(mpc, 1);
    end else begin
      driveInputs(-1, mr);
      @(negedge clk);
      checkVal("exec_cw", control_word, expCw(ir, 1'b0));
      checkVal("exec_strobes", 16'({mem_read, mem_write, halted}), 16'h0000);
      checkVal("exec_pc", 16'(pc), 16'(mpc));
      checkVal("exec_const", 16'(constant_out), ir & 16'h003F);
      lastCw = control_word;
      case (op)
        8:       mpc = Z ? wrapAdd(mpc, off) : wrapAdd(mpc, 1);
        9:       mpc = N ? wrapAdd(mpc, off) : wrapAdd(mpc, 1);
        10:      mpc = a_bus_in;
        default: mpc = wrapAdd(mpc, 1);
      endcase
      @(posedge clk); #1;
    end
  endtask

  task automatic runInstr();
    logic [15:0] ir;
    fetchCycle(ir);
    executeInstr(ir);
  endtask

  task automatic doReset();
    @(negedge clk); #1 reset = 1'b0; #1;
    checkVal("rst_pc", 16'(pc), 16'(PCR));
    checkVal("rst_cw", control_word, 16'h0000);
    checkVal("rst_flags", 16'({mem_read, mem_write, halted}), 16'h0000);
    checkVal("rst_const", 16'(constant_out), 16'h0000);
    @(posedge clk); #2 reset = 1'b1;
    mpc = PCR;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        mr;
    logic [15:0] ir;
    logic [15:0] w;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    #2;
    checkVal("por_pc", 16'(pc), 16'(PCR));
    checkVal("por_cw", control_word, 16'h0000);
    checkVal("por_flags", 16'({mem_read, mem_write, halted}), 16'h0000);
    @(posedge clk); #2 reset = 1'b1;
    mpc = PCR;

    // Directed program: ALU op, load with wait states, jumps, both branch outcomes, pc wrap.
    imem[8'h00] = 16'h2A50;
    imem[8'h01] = 16'h6A40;
    imem[8'h02] = 16'hA000;
    imem[8'h10] = 16'h81FE;
    imem[8'h0E] = 16'hA000;
    imem[8'h11] = 16'hA000;
    imem[8'hFF] = 16'h0000;
    dirMode = 1'b1; dirZ = 1'b1; dirN = 1'b0; dirABus = 8'h10; dirWait = 3;

    runInstr();
    checkVal("alu_cw_literal", lastCw, 16'hA501);
    checkVal("alu_pc_literal", 16'(pc), 16'h0001);
    runInstr();
    checkVal("load_cycles_literal", 16'(lastMemCycles), 16'd4);
    checkVal("load_final_cw_literal", lastCw, 16'hA403);
    checkVal("load_pc_literal", 16'(pc), 16'h0002);
    runInstr();
    checkVal("jump_pc_literal", 16'(pc), 16'h0010);
    runInstr();
    checkVal("branch_cw_literal", lastCw, 16'h1C00);
    checkVal("branch_taken_literal", 16'(pc), 16'h000E);
    runInstr();
    dirZ = 1'b0;
    runInstr();
    checkVal("branch_not_taken_literal", 16'(pc), 16'h0011);
    dirABus = 8'hFF;
    runInstr();
    runInstr();
    checkVal("nop_wrap_literal", 16'(pc), 16'h0000);

    // Store abandoned by reset while waiting on memory.
    imem[8'h00] = 16'hA000;
    dirABus = 8'h20;
    runInstr();
    imem[8'h20] = 16'h7050;
    dirWait = 10;
    fetchCycle(ir);
    driveInputs(0, mr);
    @(negedge clk);
    checkVal("store_cw_literal", control_word, 16'h0500);
    checkVal("store_write_literal", 16'(mem_write), 16'h0001);
    @(posedge clk); #1;
    driveInputs(1, mr);
    @(negedge clk);
    checkVal("store_wait_write", 16'(mem_write), 16'h0001);
    #1 reset = 1'b0; #1;
    checkVal("abort_write", 16'(mem_write), 16'h0000);
    checkVal("abort_cw", control_word, 16'h0000);
    checkVal("abort_pc", 16'(pc), 16'(PCR));
    checkVal("abort_const", 16'(constant_out), 16'h0000);
    @(posedge clk); #2 reset = 1'b1;
    mpc = PCR;

    // Halt is absorbing until a reset pulse.
    imem[8'h00] = 16'hF000;
    runInstr();
    checkVal("halt_literal", 16'(halted), 16'h0001);
    doReset();

    // Random programs with random flags, A-bus and memory latency.
    dirMode = 1'b0;
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'hF) w[15:12] = 4'h0;
        imem[i] = w;
      end
      for (int n = 0; n < 100; n++) runInstr();
      doReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
